// File: rtl/clkgen_multi_pkg.sv
// -----------------------------------------------------------------------------
// clkgen_multi_pkg
//
// Shared types and helpers for the multi-channel clock generator.
//
//   CLKGEN_CFG_W        width of the fields inside clkgen_cfg_t. The channel
//                       counters are narrower (CNT_W) and are zero-extended
//                       into this struct for normalisation, so CNT_W must
//                       stay below CLKGEN_CFG_W.
//   CLKGEN_DEFAULT_DIV  period used when a programmed divisor is 0.
//   clkgen_cfg_t        {div, high, start_high} channel configuration.
//   normalise_cfg()     maps a raw configuration onto a legal one:
//                         div  : 0 -> default_div, 1 -> 2
//                         high : 0 -> floor(div/2), high >= div -> div-1
//                       The high rules use the already-normalised div.
// -----------------------------------------------------------------------------
package clkgen_multi_pkg;

  localparam int unsigned CLKGEN_CFG_W       = 32;
  localparam int unsigned CLKGEN_DEFAULT_DIV = 10;

  typedef struct packed {
    logic [CLKGEN_CFG_W-1:0] div;
    logic [CLKGEN_CFG_W-1:0] high;
    logic                    start_high;
  } clkgen_cfg_t;

  function automatic clkgen_cfg_t normalise_cfg(
    input clkgen_cfg_t             raw,
    input logic [CLKGEN_CFG_W-1:0] default_div
  );
    clkgen_cfg_t n;
    n = raw;
    if (raw.div == '0) begin
      n.div = default_div;
    end else if (raw.div == CLKGEN_CFG_W'(1)) begin
      // A one-cycle period cannot have both phases; stretch it to two.
      n.div = CLKGEN_CFG_W'(2);
    end
    if (raw.high == '0) begin
      n.high = n.div >> 1;
    end else if (raw.high >= n.div) begin
      // Always keep at least one low cycle so every period has a rising edge.
      n.high = n.div - CLKGEN_CFG_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/clkgen_multi_ch.sv
// -----------------------------------------------------------------------------
// clkgen_multi_ch
//
// One divided-clock channel: period counter, active and shadow configuration,
// registered clock output and rising-edge strobe.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   i_en            run enable; low holds the counter and output at 0
//   i_sync          one-cycle restart request (counter to 0, pending applies)
//   i_wr            load the shadow configuration from i_div/i_high/
//                   i_start_high; only issued while o_pending is low
//   i_div, i_high   raw period / high time (normalised when applied)
//   i_start_high    1 = period starts with the high phase
//   o_clk           divided clock, registered
//   o_rise          one-cycle pulse in the cycle o_clk goes 0->1
//   o_pending       shadow configuration waiting for a period boundary
//
// Timing: the output registered at an edge is a function of the counter value
// held during the cycle before that edge, so the output lags the counter by
// one cycle. The shadow is copied into the active configuration only at the
// edge that closes a period (counter at div-1), at a sync restart, or at any
// edge while disabled; a running period therefore never mixes two configs.
// -----------------------------------------------------------------------------
module clkgen_multi_ch
  import clkgen_multi_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_high,
  input  logic             i_start_high,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_pending
);

  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_RST_HIGH = CNT_W'(DEFAULT_DIV / 2);

  // Active configuration
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_high;
  logic             r_start_high;

  // Shadow configuration, held raw until applied
  logic [CNT_W-1:0] r_sh_div;
  logic [CNT_W-1:0] r_sh_high;
  logic             r_sh_start_high;
  logic             r_pending;

  // Counter and outputs
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_rise;

  logic             w_period_end;
  logic             w_apply;
  logic             w_next_clk;
  clkgen_cfg_t      w_raw;
  clkgen_cfg_t      w_norm;
  logic             w_unused_hi;

  always_comb begin
    w_raw            = '0;
    w_raw.div        = CLKGEN_CFG_W'(r_sh_div);
    w_raw.high       = CLKGEN_CFG_W'(r_sh_high);
    w_raw.start_high = r_sh_start_high;
    w_norm           = normalise_cfg(w_raw, CLKGEN_CFG_W'(DEFAULT_DIV));
  end

  // Normalised values never exceed the raw inputs or DEFAULT_DIV, so the
  // upper struct bits are always zero.
  assign w_unused_hi = ^{w_norm.div[CLKGEN_CFG_W-1:CNT_W],
                         w_norm.high[CLKGEN_CFG_W-1:CNT_W]};

  // ">=" rather than "==" so that an out-of-range count still closes the
  // period instead of running around the full counter range.
  assign w_period_end = (r_cnt >= (r_div - C_ONE));
  assign w_apply      = r_pending & (~i_en | i_sync | w_period_end);

  assign w_next_clk = r_start_high ? (r_cnt < r_high)
                                   : (r_cnt >= (r_div - r_high));

  // Configuration: apply and write are exclusive because a write is only
  // accepted while r_pending is low, and apply needs r_pending high. A write
  // landing on a period-end edge therefore waits for the following one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div           <= C_RST_DIV;
      r_high          <= C_RST_HIGH;
      r_start_high    <= 1'b0;
      r_sh_div        <= '0;
      r_sh_high       <= '0;
      r_sh_start_high <= 1'b0;
      r_pending       <= 1'b0;
    end else if (w_apply) begin
      r_div        <= w_norm.div[CNT_W-1:0];
      r_high       <= w_norm.high[CNT_W-1:0];
      r_start_high <= w_norm.start_high;
      r_pending    <= 1'b0;
    end else if (i_wr) begin
      r_sh_div        <= i_div;
      r_sh_high       <= i_high;
      r_sh_start_high <= i_start_high;
      r_pending       <= 1'b1;
    end
  end

  // Counter and output. A sync restart also drops the output so every
  // channel starts its new period from the low level together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_rise <= 1'b0;
    end else if (!i_en || i_sync) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_clk  <= w_next_clk;
      r_rise <= w_next_clk & ~r_clk;
      r_cnt  <= w_period_end ? '0 : (r_cnt + C_ONE);
    end
  end

  assign o_clk     = r_clk;
  assign o_rise    = r_rise;
  assign o_pending = r_pending;

endmodule

// File: rtl/clkgen_multi.sv
// -----------------------------------------------------------------------------
// clkgen_multi
//
// Derives NUM_CH independent divided clocks from clk. Each channel has a
// programmable period, high time, start polarity and run enable; new settings
// are written through a valid/ready port and take effect at period ends.
//
// Optional build macro: CLKGEN_MULTI_SYNC_EN adds input sync_in. A rising
// edge of sync_in (registered edge detect) restarts every enabled channel at
// count 0 and applies any pending configuration, phase-aligning the channels.
// Without the macro the port is absent and the counters run free.
//
// Handshake: a configuration write transfers in any cycle where cfg_valid and
// cfg_ready are both high at the rising edge of clk. cfg_ready is the inverse
// of cfg_pending for the channel addressed by cfg_ch, so a write to a channel
// that still holds an unapplied setting stalls rather than overwriting it.
// cfg_valid may be withdrawn while stalled; an index >= NUM_CH is always
// ready and the write is dropped.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   sync_in               (CLKGEN_MULTI_SYNC_EN only) phase-align request
//   cfg_valid, cfg_ready  configuration write handshake
//   cfg_ch                target channel index
//   cfg_div, cfg_high     period and high time in clk cycles
//   cfg_start_high        1 = period begins with the high phase
//   ch_en                 per-channel run enable
//   clk_out               divided clock outputs, registered
//   rise_stb              one-cycle pulse with each clk_out 0->1 transition
//   cfg_pending           shadow configuration written but not yet applied
// -----------------------------------------------------------------------------
module clkgen_multi
  import clkgen_multi_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = CLKGEN_DEFAULT_DIV
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
`ifdef CLKGEN_MULTI_SYNC_EN
  input  logic                                      sync_in,
`endif
  input  logic                                      cfg_valid,
  output logic                                      cfg_ready,
  input  logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                          cfg_div,
  input  logic [CNT_W-1:0]                          cfg_high,
  input  logic                                      cfg_start_high,
  input  logic [NUM_CH-1:0]                         ch_en,
  output logic [NUM_CH-1:0]                         clk_out,
  output logic [NUM_CH-1:0]                         rise_stb,
  output logic [NUM_CH-1:0]                         cfg_pending
);

  localparam int CH_W = $clog2((NUM_CH > 1) ? NUM_CH : 2);

  logic              w_sync;
  logic [NUM_CH-1:0] w_wr;

  // Ready decode; out-of-range indices fall through as ready.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~cfg_pending[i];
      end
    end
  end

`ifdef CLKGEN_MULTI_SYNC_EN
  logic r_sync_d;
  logic r_sync_rise;

  // The edge is registered so the restart reaches all channels from a flop,
  // one cycle after sync_in is first seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_d    <= 1'b0;
      r_sync_rise <= 1'b0;
    end else begin
      r_sync_d    <= sync_in;
      r_sync_rise <= sync_in & ~r_sync_d;
    end
  end

  assign w_sync = r_sync_rise;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

    clkgen_multi_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_en         (ch_en[g]),
      .i_sync       (w_sync),
      .i_wr         (w_wr[g]),
      .i_div        (cfg_div),
      .i_high       (cfg_high),
      .i_start_high (cfg_start_high),
      .o_clk        (clk_out[g]),
      .o_rise       (rise_stb[g]),
      .o_pending    (cfg_pending[g])
    );
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// -----------------------------------------------------------------------------
// tb_clkgen_multi
//
// Bench for clkgen_multi (NUM_CH=4, CNT_W=16, DEFAULT_DIV=10). Inputs change
// just after the falling edge, outputs are compared at the following falling
// edge against a per-channel reference model built from the period / high
// window rules and the boundary-apply rule.
// -----------------------------------------------------------------------------
module tb_clkgen_multi;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 10;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_high;
  logic              cfg_start_high;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] rise_stb;
  logic [NUM_CH-1:0] cfg_pending;
`ifdef CLKGEN_MULTI_SYNC_EN
  logic              sync_in = 1'b0;
`endif

  always #5 clk = ~clk;

  clkgen_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef CLKGEN_MULTI_SYNC_EN
    .sync_in        (sync_in),
`endif
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_ch         (cfg_ch),
    .cfg_div        (cfg_div),
    .cfg_high       (cfg_high),
    .cfg_start_high (cfg_start_high),
    .ch_en          (ch_en),
    .clk_out        (clk_out),
    .rise_stb       (rise_stb),
    .cfg_pending    (cfg_pending)
  );

  // ---------------- reference model ----------------
  // Per channel: active {div, high, sh}, shadow, pending flag, position in
  // the current period, and the output values visible after the last edge.
  int  m_div  [NUM_CH];
  int  m_high [NUM_CH];
  bit  m_sh   [NUM_CH];
  int  s_div  [NUM_CH];
  int  s_high [NUM_CH];
  bit  s_sh   [NUM_CH];
  bit  m_pend [NUM_CH];
  int  m_pos  [NUM_CH];
  bit  m_out  [NUM_CH];
  bit  m_rise [NUM_CH];

  int   n_tests;
  int   n_fail;
  logic last_ready;

  function automatic int norm_div(input int d);
    if (d == 0) return DEF_DIV;
    if (d == 1) return 2;
    return d;
  endfunction

  function automatic int norm_high(input int h, input int d);
    if (h == 0) return d / 2;
    if (h >= d) return d - 1;
    return h;
  endfunction

  // High window of a period: the first h positions, or the last h positions.
  function automatic bit in_high_window(input int p, input int d, input int h, input bit sh);
    if (sh) return (p < h);
    return (p >= d - h);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c]  = DEF_DIV;
      m_high[c] = DEF_DIV / 2;
      m_sh[c]   = 1'b0;
      s_div[c]  = 0;
      s_high[c] = 0;
      s_sh[c]   = 1'b0;
      m_pend[c] = 1'b0;
      m_pos[c]  = 0;
      m_out[c]  = 1'b0;
      m_rise[c] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] en, input bit acc, input int ch,
                            input int d, input int h, input bit sh);
    for (int c = 0; c < NUM_CH; c++) begin
      bit last;
      bit nxt;
      last = (m_pos[c] == m_div[c] - 1);
      if (en[c]) begin
        nxt       = in_high_window(m_pos[c], m_div[c], m_high[c], m_sh[c]);
        m_rise[c] = nxt && !m_out[c];
        m_out[c]  = nxt;
        m_pos[c]  = last ? 0 : m_pos[c] + 1;
      end else begin
        m_out[c]  = 1'b0;
        m_rise[c] = 1'b0;
        m_pos[c]  = 0;
      end
      if (m_pend[c] && (!en[c] || last)) begin
        m_div[c]  = norm_div(s_div[c]);
        m_high[c] = norm_high(s_high[c], m_div[c]);
        m_sh[c]   = s_sh[c];
        m_pend[c] = 1'b0;
      end else if (acc && ch == c) begin
        s_div[c]  = d;
        s_high[c] = h;
        s_sh[c]   = sh;
        m_pend[c] = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns at the next falling edge.
  task automatic drive_cycle(input logic [NUM_CH-1:0] en, input bit v, input int ch,
                             input int d, input int h, input bit sh);
    bit               acc;
    logic [NUM_CH-1:0] eo, er, ep;
    ch_en          = en;
    cfg_valid      = v;
    cfg_ch         = 2'(ch);
    cfg_div        = CNT_W'(d);
    cfg_high       = CNT_W'(h);
    cfg_start_high = sh;
    #1;
    last_ready = cfg_ready;
    check("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend[ch]});
    acc = v && !m_pend[ch];
    @(posedge clk);
    model_step(en, acc, ch, d, h, sh);
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      eo[c] = m_out[c];
      er[c] = m_rise[c];
      ep[c] = m_pend[c];
    end
    check("clk_out", 32'(clk_out), 32'(eo));
    check("rise_stb", 32'(rise_stb), 32'(er));
    check("cfg_pending", 32'(cfg_pending), 32'(ep));
    cfg_valid = 1'b0;
  endtask

  // Runs idle cycles and measures channel c: index of the first rising
  // strobe (1 = first cycle), distance between the first two strobes and
  // the number of high cycles between them (0 if fewer than two strobes).
  task automatic measure(input int c, input logic [NUM_CH-1:0] en, input int cycles,
                         output int first, output int period, output int high_t);
    int rises[$];
    bit hist[$];
    first  = 0;
    period = 0;
    high_t = 0;
    for (int k = 1; k <= cycles; k++) begin
      drive_cycle(en, 1'b0, 0, 0, 0, 1'b0);
      hist.push_back(clk_out[c]);
      if (rise_stb[c]) rises.push_back(k);
    end
    if (rises.size() >= 1) first = rises[0];
    if (rises.size() >= 2) begin
      period = rises[1] - rises[0];
      for (int k = rises[0]; k < rises[1]; k++) high_t += int'(hist[k-1]);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int div;
    int high;
    bit sh;
    int exp_first;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int first, per, hi, pend_cnt, k;
    logic [NUM_CH-1:0] cur_en;

    // div, high, start_high, first rise, period, high time
    vecs[0] = '{7, 2, 1'b1, 1, 7, 2};
    vecs[1] = '{0, 0, 1'b0, 6, 10, 5};
    vecs[2] = '{1, 0, 1'b0, 2, 2, 1};
    vecs[3] = '{5, 9, 1'b0, 2, 5, 4};
    vecs[4] = '{8, 3, 1'b0, 6, 8, 3};
    vecs[5] = '{3, 0, 1'b1, 1, 3, 1};

    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    cfg_valid      = 1'b0;
    cfg_ch         = '0;
    cfg_div        = '0;
    cfg_high       = '0;
    cfg_start_high = 1'b0;
    ch_en          = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_rise_stb", 32'(rise_stb), 32'd0);
    check("rst_pending", 32'(cfg_pending), 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults on ch0: first rise after 6 cycles, 10-cycle period, 5 high
    measure(0, 4'b0001, 30, first, per, hi);
    check("dflt_first", first, 6);
    check("dflt_period", per, 10);
    check("dflt_high", hi, 5);

    // Table: program ch1 while disabled, then enable and measure
    foreach (vecs[i]) begin
      drive_cycle(4'b0001, 1'b1, 1, vecs[i].div, vecs[i].high, vecs[i].sh);
      check("tbl_accept", {31'd0, last_ready}, 32'd1);
      drive_cycle(4'b0001, 1'b0, 0, 0, 0, 1'b0);
      measure(1, 4'b0011, 30, first, per, hi);
      check("tbl_first", first, vecs[i].exp_first);
      check("tbl_period", per, vecs[i].exp_period);
      check("tbl_high", hi, vecs[i].exp_high);
      drive_cycle(4'b0001, 1'b0, 0, 0, 0, 1'b0);
    end

    // Mid-period reconfig of ch0 at count 3: pending covers counts 4..9
    k = 0;
    while (m_pos[0] != 3 && k < 20) begin
      drive_cycle(4'b0001, 1'b0, 0, 0, 0, 1'b0);
      k++;
    end
    check("wait_pos3", m_pos[0], 3);
    drive_cycle(4'b0001, 1'b1, 0, 4, 0, 1'b0);
    check("mid_accept", {31'd0, last_ready}, 32'd1);
    pend_cnt = int'(cfg_pending[0]);
    // Second write to the same channel must stall
    drive_cycle(4'b0001, 1'b1, 0, 6, 0, 1'b0);
    check("b2b_stall", {31'd0, last_ready}, 32'd0);
    pend_cnt += int'(cfg_pending[0]);
    // A different channel is accepted meanwhile
    drive_cycle(4'b0001, 1'b1, 2, 5, 2, 1'b0);
    check("other_ch_accept", {31'd0, last_ready}, 32'd1);
    pend_cnt += int'(cfg_pending[0]);
    for (int j = 0; j < 10; j++) begin
      drive_cycle(4'b0001, 1'b0, 0, 0, 0, 1'b0);
      pend_cnt += int'(cfg_pending[0]);
    end
    check("pend_cycles", pend_cnt, 6);
    measure(0, 4'b0001, 20, first, per, hi);
    check("new_period", per, 4);
    check("new_high", hi, 2);

    // Disable ch2 during its high phase, then re-enable
    k = 0;
    while (!m_out[2] && k < 20) begin
      drive_cycle(4'b0101, 1'b0, 0, 0, 0, 1'b0);
      k++;
    end
    check("ch2_high_seen", {31'd0, clk_out[2]}, 32'd1);
    drive_cycle(4'b0001, 1'b0, 0, 0, 0, 1'b0);
    check("dis_clk", {31'd0, clk_out[2]}, 32'd0);
    check("dis_rise", {31'd0, rise_stb[2]}, 32'd0);
    for (int j = 0; j < 3; j++) begin
      drive_cycle(4'b0001, 1'b0, 0, 0, 0, 1'b0);
      check("dis_hold_rise", {31'd0, rise_stb[2]}, 32'd0);
    end
    measure(2, 4'b0101, 20, first, per, hi);
    check("reen_first", first, 4);
    check("reen_period", per, 5);
    check("reen_high", hi, 2);

    // Randomized traffic against the model
    cur_en = 4'b1111;
    for (int j = 0; j < 3000; j++) begin
      int b;
      if ($urandom_range(0, 39) == 0) begin
        b = int'($urandom_range(0, NUM_CH-1));
        cur_en[b] = ~cur_en[b];
      end
      if ($urandom_range(0, 2) == 0)
        drive_cycle(cur_en, 1'b1, int'($urandom_range(0, NUM_CH-1)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
                    1'($urandom_range(0, 1)));
      else
        drive_cycle(cur_en, 1'b0, 0, 0, 0, 1'b0);
    end

    // Asynchronous reset in mid-cycle discards everything
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_clk_out", 32'(clk_out), 32'd0);
    check("arst_rise_stb", 32'(rise_stb), 32'd0);
    check("arst_pending", 32'(cfg_pending), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    measure(3, 4'b1111, 30, first, per, hi);
    check("post_rst_first", first, 6);
    check("post_rst_period", per, 10);
    check("post_rst_high", hi, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
